pll_reconfig: RTL and testbench



---
 rtl/pll_reconfig.sv | 201 ++++++++++++++++++++
 tb/tb_pll_reconfig.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig.sv
// pll_reconfig: retunes the MMCM between stored presets at run time.
// Holds the MMCM in reset, walks one preset's register list from an external
// ROM, applies each entry to the DRP as a read-modify-write, then releases
// reset, waits for lock and only then re-enables the downstream clock buffer.
module pll_reconfig #(
   parameter int  NUM_PRESETS     = 4,
   parameter int  REGS_PER_PRESET = 23,
   parameter int  LOCK_TIMEOUT    = 65535,
   parameter int  DRP_TIMEOUT     = 255,
   localparam int PRESET_W        = (NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1,
   localparam int ROM_AW          = (NUM_PRESETS * REGS_PER_PRESET > 1) ?
                                    $clog2(NUM_PRESETS * REGS_PER_PRESET) : 1
) (
   input  logic                clk,
   input  logic                resetN,
   input  logic                start,
   input  logic [PRESET_W-1:0] preset,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [ROM_AW-1:0]   romAddr,
   input  logic [38:0]         romData,
   output logic [6:0]          dAddr,
   output logic [15:0]         dI,
   input  logic [15:0]         dO,
   output logic                dEn,
   output logic                dWe,
   input  logic                dRdy,
   output logic                mmcmRst,
   input  logic                mmcmLocked,
   output logic                clkEnable
);

   localparam int IDX_W  = (REGS_PER_PRESET > 1) ? $clog2(REGS_PER_PRESET) : 1;
   localparam int T_MAX  = (LOCK_TIMEOUT > DRP_TIMEOUT) ? LOCK_TIMEOUT : DRP_TIMEOUT;
   localparam int CNT_W  = $clog2(T_MAX + 1);

   localparam logic [PRESET_W:0]   PRESET_LIMIT = (PRESET_W + 1)'(NUM_PRESETS);
   localparam logic [IDX_W-1:0]    LAST_IDX     = IDX_W'(REGS_PER_PRESET - 1);
   localparam logic [CNT_W-1:0]    LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]    DRP_LAST     = CNT_W'(DRP_TIMEOUT - 1);
   localparam logic [ROM_AW-1:0]   ROM_STRIDE   = ROM_AW'(REGS_PER_PRESET);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_RD,
      S_RDWAIT,
      S_WR,
      S_WRWAIT,
      S_LOCKWAIT
   } state_t;

   state_t              state;
   logic [PRESET_W-1:0] cur_preset;
   logic [IDX_W-1:0]    index;
   logic [CNT_W-1:0]    cnt;
   logic [15:0]         ent_mask;
   logic [15:0]         ent_data;
   logic                locked_meta;
   logic                locked_s;

   // Two-flop synchroniser for the asynchronous MMCM LOCKED output.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         locked_meta <= 1'b0;
         locked_s    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make both flops sample together, so
         // the chain really is two stages deep regardless of statement order.
         locked_meta <= mmcmLocked;
         locked_s    <= locked_meta;
      end
   end

   // Sequencer: fetch entry, DRP read, merge under mask, DRP write, then lock wait.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state      <= S_IDLE;
         cur_preset <= '0;
         index      <= '0;
         cnt        <= '0;
         ent_mask   <= '0;
         ent_data   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         romAddr    <= '0;
         dAddr      <= '0;
         dI         <= '0;
         dEn        <= 1'b0;
         dWe        <= 1'b0;
         mmcmRst    <= 1'b0;
         clkEnable  <= 1'b0;
      end else begin
         // Strobes are single-cycle unless a state below re-asserts them.
         done <= 1'b0;
         dEn  <= 1'b0;
         dWe  <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start && ({1'b0, preset} < PRESET_LIMIT)) begin
                  cur_preset <= preset;
                  error      <= 1'b0;
                  busy       <= 1'b1;
                  mmcmRst    <= 1'b1;
                  clkEnable  <= 1'b0;
                  index      <= '0;
                  romAddr    <= ROM_AW'(preset) * ROM_STRIDE;
                  state      <= S_FETCH;
               end else if (start) begin
                  // Out-of-range preset: flag it and leave the MMCM untouched.
                  error     <= 1'b1;
                  clkEnable <= 1'b0;
               end else begin
                  clkEnable <= locked_s & ~error;
               end
            end

            // romAddr is already presented; the ROM answers one cycle later.
            S_FETCH: state <= S_LATCH;

            S_LATCH: begin
               dAddr    <= romData[38:32];
               ent_mask <= romData[31:16];
               ent_data <= romData[15:0];
               dEn      <= 1'b1;
               state    <= S_RD;
            end

            S_RD: begin
               cnt   <= '0;
               state <= S_RDWAIT;
            end

            S_RDWAIT: begin
               if (dRdy) begin
                  // Keep-mask bits preserve the current register contents.
                  dI    <= (dO & ent_mask) | (ent_data & ~ent_mask);
                  dEn   <= 1'b1;
                  dWe   <= 1'b1;
                  state <= S_WR;
               end else if (cnt == DRP_LAST) begin
                  error   <= 1'b1;
                  mmcmRst <= 1'b0;
                  busy    <= 1'b0;
                  state   <= S_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            S_WR: begin
               cnt   <= '0;
               state <= S_WRWAIT;
            end

            S_WRWAIT: begin
               if (dRdy) begin
                  if (index == LAST_IDX) begin
                     mmcmRst <= 1'b0;
                     cnt     <= '0;
                     state   <= S_LOCKWAIT;
                  end else begin
                     index   <= index + IDX_W'(1);
                     romAddr <= ROM_AW'(cur_preset) * ROM_STRIDE + ROM_AW'(index) + ROM_AW'(1);
                     state   <= S_FETCH;
                  end
               end else if (cnt == DRP_LAST) begin
                  // Partial configuration stays in place; software must retry.
                  error   <= 1'b1;
                  mmcmRst <= 1'b0;
                  busy    <= 1'b0;
                  state   <= S_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            S_LOCKWAIT: begin
               if (locked_s) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else if (cnt == LOCK_LAST) begin
                  error <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pll_reconfig.sv
// tb_pll_reconfig: drives pll_reconfig with a ROM model, a DRP register-file
// responder and an MMCM lock model, and compares the DRP write stream and the
// final register file against a masked-merge reference computed here.
module tb_pll_reconfig;

   localparam int NP = 3;      // 2-bit preset port, so preset 3 is out of range
   localparam int RP = 23;
   localparam int LT = 1000;
   localparam int DT = 255;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  preset = '0;
   logic        busy, done, error, dEn, dWe, mmcmRst, clkEnable;
   logic [6:0]  romAddr, dAddr;
   logic [38:0] romData = '0;
   logic [15:0] dI;
   logic [15:0] dO = '0;
   logic        dRdy = 1'b0;
   logic        mmcmLocked;

   pll_reconfig #(
      .NUM_PRESETS(NP), .REGS_PER_PRESET(RP), .LOCK_TIMEOUT(LT), .DRP_TIMEOUT(DT)
   ) dut (
      .clk(clk), .resetN(resetN), .start(start), .preset(preset),
      .busy(busy), .done(done), .error(error), .romAddr(romAddr), .romData(romData),
      .dAddr(dAddr), .dI(dI), .dO(dO), .dEn(dEn), .dWe(dWe), .dRdy(dRdy),
      .mmcmRst(mmcmRst), .mmcmLocked(mmcmLocked), .clkEnable(clkEnable)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // ROM with one cycle of read latency.
   logic [38:0] rom [NP*RP];
   always @(posedge clk)
      romData <= (int'(romAddr) < NP*RP) ? rom[int'(romAddr)] : 39'd0;

   // DRP register file with configurable response latency and a mute switch.
   logic [15:0] drp_regs  [128] = '{default: 16'hFFFF};
   logic [15:0] model_regs[128] = '{default: 16'hFFFF};
   logic [22:0] act_wr[$];
   logic [22:0] exp_wr[$];
   bit          drp_mute = 1'b0;
   bit          drp_rand = 1'b0;
   bit          pend = 1'b0;
   bit          prev_den = 1'b0;
   bit          proto_err = 1'b0;
   int          pw = 0;
   logic [6:0]  pa = '0;
   logic        pwe = 1'b0;
   logic [15:0] pdi = '0;
   int          den_cnt = 0;

   always @(posedge clk) begin : drp_model
      int unsigned lat;
      dRdy     <= 1'b0;
      prev_den <= dEn;
      if (dEn) begin
         den_cnt <= den_cnt + 1;
         if (pend || prev_den) proto_err <= 1'b1;
         if (dWe) act_wr.push_back({dAddr, dI});
         lat = drp_rand ? $urandom_range(4, 1) : 1;
         if (!drp_mute) begin
            if (lat == 1) begin
               dRdy <= 1'b1;
               if (dWe) drp_regs[dAddr] <= dI;
               else     dO <= drp_regs[dAddr];
            end else begin
               pend <= 1'b1;
               pw   <= int'(lat) - 2;
               pa   <= dAddr;
               pwe  <= dWe;
               pdi  <= dI;
            end
         end
      end else if (pend) begin
         if (pw == 0) begin
            pend <= 1'b0;
            dRdy <= 1'b1;
            if (pwe) drp_regs[pa] <= pdi;
            else     dO <= drp_regs[pa];
         end else begin
            pw <= pw - 1;
         end
      end
   end

   // MMCM: locks lock_delay negedges after reset release, or follows lock_val.
   int   lock_delay = 10;
   bit   lock_auto = 1'b1;
   bit   lock_val = 1'b0;
   logic auto_lock = 1'b0;
   int   lcnt = 0;
   always @(negedge clk) begin
      if (mmcmRst === 1'b1) begin
         auto_lock <= 1'b0;
         lcnt      <= 0;
      end else if (!auto_lock) begin
         if (lcnt == lock_delay) auto_lock <= 1'b1;
         else                    lcnt <= lcnt + 1;
      end
   end
   assign mmcmLocked = lock_auto ? auto_lock : lock_val;

   int done_cnt = 0;
   always @(negedge clk) done_cnt <= done_cnt + int'(done);

   // Reference: each entry merges ROM data into the register under its keep-mask.
   function automatic void build_expected(input int p, input int n);
      for (int i = 0; i < n; i++) begin
         logic [38:0] e;
         logic [15:0] nv;
         e  = rom[p*RP + i];
         nv = (model_regs[e[38:32]] & e[31:16]) | (e[15:0] & ~e[31:16]);
         model_regs[e[38:32]] = nv;
         exp_wr.push_back({e[38:32], nv});
      end
   endfunction

   task automatic compare_writes(input int base, input int n, input string tag);
      check({tag, "_write_count"}, act_wr.size() - base, n);
      for (int i = 0; i < n && base + i < act_wr.size(); i++)
         check($sformatf("%s_write_%0d", tag, i), act_wr[base+i], exp_wr[i]);
   endtask

   task automatic run_preset(input int p, input int ld, input bit rnd, input bit timed, input string tag);
      int base_wr, base_done, base_den, n, n0, rst_hi;
      bit fell, got;
      lock_delay = ld;
      drp_rand   = rnd;
      exp_wr.delete();
      build_expected(p, RP);
      base_wr = act_wr.size(); base_done = done_cnt; base_den = den_cnt;
      preset = 2'(p); start = 1'b1;
      tick();
      start = 1'b0;
      if (timed) begin
         check({tag, "_busy_c1"}, busy, 1);
         check({tag, "_mmcm_rst_c1"}, mmcmRst, 1);
         check({tag, "_clk_enable_c1"}, clkEnable, 0);
         check({tag, "_rom_addr_c1"}, romAddr, p*RP);
      end
      n = 0; n0 = 0; rst_hi = 0; fell = 0; got = 0;
      while (!got && n < 5000) begin
         if (!fell) begin
            if (mmcmRst) rst_hi++;
            else begin fell = 1; n0 = n; end
         end
         if (done) got = 1;
         else begin tick(); n++; end
      end
      check({tag, "_done_seen"}, got, 1);
      if (timed) begin
         check({tag, "_rst_high_cycles"}, rst_hi, RP*6);
         check({tag, "_done_latency"}, n - n0, ld + 3);
      end
      tick();
      check({tag, "_clk_enable"}, clkEnable, 1);
      check({tag, "_busy_after"}, busy, 0);
      check({tag, "_error_after"}, error, 0);
      check({tag, "_done_one_cycle"}, done, 0);
      tick(); tick();
      check({tag, "_done_pulses"}, done_cnt - base_done, 1);
      check({tag, "_drp_accesses"}, den_cnt - base_den, 2*RP);
      if (timed && act_wr.size() > base_wr)
         check({tag, "_first_write"}, act_wr[base_wr], {7'h08, 16'h1041});
      compare_writes(base_wr, RP, tag);
   endtask

   typedef struct {
      bit         do_reset;
      logic [1:0] p;
      logic       exp_busy;
      logic       exp_error;
      logic       exp_rst;
      logic [6:0] exp_addr;
   } vec_t;

   initial begin
      vec_t vecs[5];
      int   k, n, m, base_wr, base_den, mism;

      for (int i = 0; i < NP*RP; i++)
         rom[i] = {7'($urandom), 16'($urandom), 16'($urandom)};
      rom[RP] = {7'h08, 16'h1000, 16'h0041};

      // Reset state.
      tick(); tick();
      check("rst_flags", {busy, done, error, dEn, dWe, mmcmRst, clkEnable}, 0);
      check("rst_rom_addr", romAddr, 0);
      check("rst_daddr", dAddr, 0);
      check("rst_di", dI, 0);
      resetN = 1'b1;
      tick();

      // Start acceptance and preset range, one cycle after start.
      vecs[0] = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 7'd0};
      vecs[1] = '{1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 7'd46};
      vecs[2] = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 7'd0};
      vecs[3] = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 7'd23};
      vecs[4] = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 7'd0};
      for (int i = 0; i < 5; i++) begin
         if (vecs[i].do_reset) begin
            resetN = 1'b0; tick(); resetN = 1'b1; tick();
         end
         preset = vecs[i].p; start = 1'b1;
         tick();
         start = 1'b0;
         check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
         check($sformatf("vec%0d_error", i), error, vecs[i].exp_error);
         check($sformatf("vec%0d_mmcm_rst", i), mmcmRst, vecs[i].exp_rst);
         check($sformatf("vec%0d_rom_addr", i), romAddr, vecs[i].exp_addr);
         check($sformatf("vec%0d_den", i), dEn, 0);
      end
      resetN = 1'b0; tick(); resetN = 1'b1;
      repeat (20) tick();

      // Normal sequence, preset 1, lock 100 cycles after reset release.
      run_preset(1, 100, 1'b0, 1'b1, "normal");

      // Lock timeout: lock held low.
      lock_auto = 1'b0; lock_val = 1'b0;
      exp_wr.delete(); build_expected(0, RP);
      base_wr = act_wr.size(); k = done_cnt;
      preset = 2'd0; start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (mmcmRst && n < 2000) begin tick(); n++; end
      m = 0;
      while (!error && m < 1500) begin tick(); m++; end
      check("lock_timeout_cycles", m, LT);
      check("lock_timeout_busy", busy, 0);
      check("lock_timeout_clk_enable", clkEnable, 0);
      compare_writes(base_wr, RP, "lock_timeout");
      lock_val = 1'b1;
      repeat (6) tick();
      check("lock_timeout_ce_gated_by_error", clkEnable, 0);
      check("lock_timeout_no_done", done_cnt - k, 0);
      lock_auto = 1'b1;

      // DRP timeout: dRdy never comes.
      drp_mute = 1'b1;
      base_den = den_cnt;
      preset = 2'd1; start = 1'b1; tick(); start = 1'b0;
      check("drp_start_clears_error", error, 0);
      n = 0;
      while (!dEn && n < 20) begin tick(); n++; end
      check("drp_den_seen", dEn, 1);
      m = 0;
      while (!error && m < 400) begin tick(); m++; end
      check("drp_timeout_cycles", m, DT + 1);
      check("drp_timeout_mmcm_rst", mmcmRst, 0);
      check("drp_timeout_busy", busy, 0);
      repeat (20) tick();
      check("drp_timeout_single_den", den_cnt - base_den, 1);
      drp_mute = 1'b0;

      // Start while busy is ignored; reset lands in WRWAIT of entry 10.
      drp_rand = 1'b0;
      exp_wr.delete(); build_expected(2, 11);
      base_wr = act_wr.size();
      preset = 2'd2; start = 1'b1; tick(); start = 1'b0;
      k = 0; n = 0;
      while (k < 22 && n < 1000) begin
         if (dEn) k++;
         if (k == 11 && dEn && !dWe) begin preset = 2'd0; start = 1'b1; end
         if (k < 22) begin tick(); n++; start = 1'b0; end
      end
      check("busy_test_at_wr10", {dEn, dWe}, 2'b11);
      check("busy_test_no_error", error, 0);
      tick();
      check("busy_test_still_busy", busy, 1);
      resetN = 1'b0;
      #1;
      check("midrst_flags", {busy, done, error, dEn, dWe, mmcmRst, clkEnable}, 0);
      check("midrst_rom_addr", romAddr, 0);
      check("midrst_daddr", dAddr, 0);
      check("midrst_di", dI, 0);
      tick(); resetN = 1'b1;
      repeat (20) tick();
      compare_writes(base_wr, 11, "partial");
      run_preset(0, 20, 1'b1, 1'b0, "restart");

      // Randomised presets, DRP latencies and lock delays.
      for (int r = 0; r < 5; r++)
         run_preset(int'($urandom_range(NP-1, 0)), int'($urandom_range(40, 5)), 1'b1, 1'b0,
                    $sformatf("rand%0d", r));

      // Loss and recovery of lock while idle.
      lock_val = 1'b1; lock_auto = 1'b0;
      tick();
      lock_val = 1'b0;
      tick(); tick();
      check("lock_loss_ce_c2", clkEnable, 1);
      tick();
      check("lock_loss_ce_c3", clkEnable, 0);
      lock_val = 1'b1;
      tick(); tick();
      check("lock_back_ce_c2", clkEnable, 0);
      tick();
      check("lock_back_ce_c3", clkEnable, 1);
      lock_auto = 1'b1;

      mism = 0;
      for (int a = 0; a < 128; a++)
         if (drp_regs[a] !== model_regs[a]) mism++;
      check("drp_regs_final", mism, 0);
      check("drp_protocol", proto_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
